prim_xoshiro256pp_multi: RTL and testbench

PRIM_XOSHIRO256PP_MULTI -- requirements
Module: prim_xoshiro256pp_multi

---
 rtl/prim_xoshiro_pkg.sv | 52 +++++
 rtl/prim_xoshiro256pp_lane.sv | 83 ++++++++
 rtl/prim_xoshiro256pp_multi.sv | 111 +++++++++++
 tb/tb_prim_xoshiro256pp_multi.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_xoshiro_pkg.sv
// prim_xoshiro_pkg
// Shared types and pure functions for the multi-lane xoshiro256++ generator.
// State layout: {a, b, c, d} = state[255:0], a in the MSBs.
// Contents: 256-bit state type, FSM encoding, single-step output and state
// update functions, and the per-lane default-seed rotation.
package prim_xoshiro_pkg;

    typedef logic [255:0] state_t;

    typedef enum logic [0:0] {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    function automatic logic [63:0] rotl23(input logic [63:0] x);
        return {x[40:0], x[63:41]};
    endfunction

    function automatic logic [63:0] rotr19(input logic [63:0] x);
        return {x[18:0], x[63:19]};
    endfunction

    // 64-bit output for the current state (wraps mod 2^64)
    function automatic logic [63:0] xo_out(input state_t s);
        logic [63:0] sum;
        sum = s[255:192] + s[63:0];
        return rotl23(sum) + s[255:192];
    endfunction

    // One state transition
    function automatic state_t xo_step(input state_t s);
        logic [63:0] a, b, c, d;
        a = s[255:192];
        b = s[191:128];
        c = s[127:64];
        d = s[63:0];
        return {a ^ b ^ d,
                a ^ b ^ c,
                a ^ (b << 17) ^ c,
                rotr19(d) ^ rotr19(b)};
    endfunction

    // Lane i recovery seed: base seed rotated left by 64*i bits (mod 256)
    function automatic state_t lane_default_seed(input state_t seed, input logic [2:0] lane);
        logic [511:0] dbl;
        logic [7:0]   sh;
        sh  = {lane[1:0], 6'd0};
        dbl = {seed, seed} << sh;
        return dbl[511:256];
    endfunction

endpackage

// File: rtl/prim_xoshiro256pp_lane.sv
// prim_xoshiro256pp_lane
// One generator lane: state register, LaneDw/64 unrolled steps, lock-up
// recovery and (optionally) entropy mixing.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset (state -> LaneSeed)
//   seed_load_i    load seed_i into the state (has priority over advance)
//   seed_i         256-bit seed for this lane
//   advance_i      advance the state by one output word
//   entropy_i      XOR'd into the advanced state when PRIM_XOSHIRO_ENTROPY_EN
//   word_o         LaneDw output bits from the current state (0 when locked up)
//   all_zero_o     current state is all-zero
// Macro: PRIM_XOSHIRO_ENTROPY_EN enables entropy mixing; otherwise entropy_i
// is ignored.
module prim_xoshiro256pp_lane
    import prim_xoshiro_pkg::*;
#(
    parameter int     LaneDw   = 64,
    parameter state_t LaneSeed = 256'h1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              seed_load_i,
    input  state_t            seed_i,
    input  logic              advance_i,
    input  state_t            entropy_i,
    output logic [LaneDw-1:0] word_o,
    output logic              all_zero_o
);

    localparam int NumSteps = LaneDw / 64;

    state_t            state_r;
    state_t            stepped_s;
    state_t            next_s;
    logic [LaneDw-1:0] raw_word_s;
    logic              zero_s;

    assign zero_s     = (state_r == {256{1'b0}});
    assign all_zero_o = zero_s;

    // Unrolled generation: chunk k is produced from the state before step k
    always_comb begin
        stepped_s  = state_r;
        raw_word_s = {LaneDw{1'b0}};
        for (int k = 0; k < NumSteps; k++) begin
            raw_word_s[k*64 +: 64] = xo_out(stepped_s);
            stepped_s              = xo_step(stepped_s);
        end
    end

`ifdef PRIM_XOSHIRO_ENTROPY_EN
    assign next_s = stepped_s ^ entropy_i;
`else
    logic unused_entropy_s;
    assign unused_entropy_s = ^entropy_i;
    assign next_s           = stepped_s;
`endif

    // A locked-up lane contributes zero to the word it is recovering in
    always_comb begin
        if (zero_s) begin
            word_o = {LaneDw{1'b0}};
        end else begin
            word_o = raw_word_s;
        end
    end

    // State register: seed beats advance; all-zero state reloads the recovery seed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= LaneSeed;
        end else if (seed_load_i) begin
            state_r <= seed_i;
        end else if (advance_i) begin
            if (zero_s) begin
                state_r <= LaneSeed;
            end else begin
                state_r <= next_s;
            end
        end
    end

endmodule

// File: rtl/prim_xoshiro256pp_multi.sv
// prim_xoshiro256pp_multi
// NumLanes independent xoshiro256++ lanes producing one registered
// NumLanes*LaneDw word per cycle under valid/ready flow control, with a
// seed handshake and a periodic reseed request.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   seed_valid_i/ready_o     seed handshake; seed_i holds lane 0 in the LSBs
//   entropy_i                per-lane entropy (used with PRIM_XOSHIRO_ENTROPY_EN)
//   data_valid_o/ready_i     output handshake; data_o is the registered word
//   reseed_req_o             a seed is wanted (unseeded, or interval reached)
//   all_zero_o               per-lane all-zero state flag
// Macro: PRIM_XOSHIRO_ENTROPY_EN (entropy mixing inside each lane).
module prim_xoshiro256pp_multi
    import prim_xoshiro_pkg::*;
#(
    parameter int unsigned NumLanes       = 2,
    parameter int unsigned LaneDw         = 64,
    parameter int unsigned ReseedInterval = 32'd1024,
    parameter state_t      DefaultSeed    = 256'h1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         seed_valid_i,
    output logic                         seed_ready_o,
    input  logic [NumLanes*256-1:0]      seed_i,
    input  logic [NumLanes*256-1:0]      entropy_i,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic [NumLanes*LaneDw-1:0]   data_o,
    output logic                         reseed_req_o,
    output logic [NumLanes-1:0]          all_zero_o
);

    fsm_e                        fsm_r;
    logic [31:0]                 count_r;
    logic                        valid_r;
    logic [NumLanes*LaneDw-1:0]  data_r;
    logic [NumLanes*LaneDw-1:0]  word_all_s;
    logic                        seed_hs_s;
    logic                        data_hs_s;
    logic                        load_s;

    // Both flags derive only from registers, so reset forces them at once
    assign reseed_req_o = (fsm_r == ST_SEED) ||
                          ((ReseedInterval != 32'd0) && (count_r == ReseedInterval));
    assign seed_ready_o = (fsm_r == ST_SEED) || reseed_req_o;
    assign seed_hs_s    = seed_valid_i && seed_ready_o;
    assign data_hs_s    = valid_r && data_ready_i;
    assign load_s       = (fsm_r == ST_RUN) && (!valid_r || data_ready_i);

    assign data_valid_o = valid_r;
    assign data_o       = data_r;

    for (genvar i = 0; i < NumLanes; i++) begin : g_lane
        prim_xoshiro256pp_lane #(
            .LaneDw   (LaneDw),
            .LaneSeed (lane_default_seed(DefaultSeed, 3'(i)))
        ) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .seed_load_i (seed_hs_s),
            .seed_i      (seed_i[i*256 +: 256]),
            .advance_i   (load_s),
            .entropy_i   (entropy_i[i*256 +: 256]),
            .word_o      (word_all_s[i*LaneDw +: LaneDw]),
            .all_zero_o  (all_zero_o[i])
        );
    end

    // Control FSM: leaves SEED on the first seed handshake, only reset returns it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_r <= ST_SEED;
        end else begin
            case (fsm_r)
                ST_SEED: begin
                    if (seed_hs_s) begin
                        fsm_r <= ST_RUN;
                    end
                end
                ST_RUN:  fsm_r <= ST_RUN;
                default: fsm_r <= ST_SEED;
            endcase
        end
    end

    // Output handshake counter, saturating at the reseed interval
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= 32'd0;
        end else if (seed_hs_s) begin
            count_r <= 32'd0;
        end else if (data_hs_s && (count_r != ReseedInterval)) begin
            count_r <= count_r + 32'd1;
        end
    end

    // Output word register: captured from the pre-advance lane states
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= 1'b0;
            data_r  <= {(NumLanes*LaneDw){1'b0}};
        end else if (load_s) begin
            valid_r <= 1'b1;
            data_r  <= word_all_s;
        end else if (data_hs_s) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prim_xoshiro256pp_multi.sv
// tb_prim_xoshiro256pp_multi
// Self-checking bench: a cycle-level behavioural model of the generator
// (lane states as four 64-bit words, plain arithmetic) is advanced alongside
// the DUT and all outputs are compared every cycle, plus directed checks for
// latency, known first outputs, lock-up recovery, reseed and async reset.
// Honours PRIM_XOSHIRO_ENTROPY_EN in the model.
module tb_prim_xoshiro256pp_multi;

    localparam int unsigned NL   = 2;
    localparam int unsigned LDW  = 128;
    localparam int unsigned RI   = 4;
    localparam logic [255:0] DSEED =
        256'h9E3779B97F4A7C15_BF58476D1CE4E5B9_94D049BB133111EB_2545F4914F6CDD1D;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  seed_valid;
    logic                  seed_ready;
    logic [NL*256-1:0]     seed;
    logic [NL*256-1:0]     ent;
    logic                  data_valid;
    logic                  data_ready;
    logic [NL*LDW-1:0]     data;
    logic                  reseed_req;
    logic [NL-1:0]         all_zero;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [255:0]      m_st [NL];
    logic              m_run;
    int unsigned       m_cnt;
    logic              m_valid;
    logic [NL*LDW-1:0] m_data;
    logic              m_shs;

    always #5 clk = ~clk;

    prim_xoshiro256pp_multi #(
        .NumLanes       (NL),
        .LaneDw         (LDW),
        .ReseedInterval (RI),
        .DefaultSeed    (DSEED)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .seed_valid_i (seed_valid),
        .seed_ready_o (seed_ready),
        .seed_i       (seed),
        .entropy_i    (ent),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .data_o       (data),
        .reseed_req_o (reseed_req),
        .all_zero_o   (all_zero)
    );

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, req);
        end
    endtask

    function automatic logic [63:0] rol(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] word_of(input logic [255:0] s, input int i);
        return s[255 - 64*i -: 64];   // i=0 -> a ... i=3 -> d
    endfunction

    function automatic logic [63:0] m_out(input logic [255:0] s);
        return rol(word_of(s, 0) + word_of(s, 3), 23) + word_of(s, 0);
    endfunction

    function automatic logic [255:0] m_step(input logic [255:0] s);
        logic [63:0] a, b, c, d;
        a = word_of(s, 0); b = word_of(s, 1); c = word_of(s, 2); d = word_of(s, 3);
        return {a ^ b ^ d, a ^ b ^ c, a ^ (b << 17) ^ c, rol(d, 45) ^ rol(b, 45)};
    endfunction

    function automatic logic [255:0] m_dflt(input int lane);
        int n;
        n = 64 * (lane % 4);
        return (DSEED << n) | (DSEED >> (256 - n));
    endfunction

    function automatic logic m_rreq();
        return !m_run || (m_cnt == RI);
    endfunction

    function automatic logic [NL-1:0] m_zero();
        logic [NL-1:0] z;
        for (int l = 0; l < NL; l++) z[l] = (m_st[l] == 256'd0);
        return z;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NL; l++) m_st[l] = m_dflt(l);
        m_run = 1'b0; m_cnt = 0; m_valid = 1'b0; m_data = '0; m_shs = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".valid"}, 512'(data_valid), 512'(m_valid));
        if (m_valid) check_val({tag, ".data"}, 512'(data), 512'(m_data));
        check_val({tag, ".rreq"}, 512'(reseed_req), 512'(m_rreq()));
        check_val({tag, ".sready"}, 512'(seed_ready), 512'(m_rreq()));
        check_val({tag, ".zero"}, 512'(all_zero), 512'(m_zero()));
    endtask

    // one clock: model computes the next state from the current inputs, then compare
    task automatic tick(input string tag);
        logic              shs, ld, dhs;
        logic [255:0]      nst [NL];
        logic [255:0]      s;
        logic [255:0]      e;
        logic [NL*LDW-1:0] w;
        shs = seed_valid && m_rreq();
        ld  = m_run && (!m_valid || data_ready);
        dhs = m_valid && data_ready;
        w   = '0;
        for (int l = 0; l < NL; l++) begin
            s = m_st[l];
            nst[l] = s;
`ifdef PRIM_XOSHIRO_ENTROPY_EN
            e = ent[l*256 +: 256];
`else
            e = 256'd0;
`endif
            if (ld) begin
                if (s == 256'd0) begin
                    nst[l] = m_dflt(l);
                end else begin
                    for (int k = 0; k < LDW / 64; k++) begin
                        w[l*LDW + 64*k +: 64] = m_out(s);
                        s = m_step(s);
                    end
                    nst[l] = s ^ e;
                end
            end
            if (shs) nst[l] = seed[l*256 +: 256];
        end
        @(posedge clk);
        #1;
        m_st = nst;
        if (ld) begin
            m_valid = 1'b1;
            m_data  = w;
        end else if (dhs) begin
            m_valid = 1'b0;
        end
        if (shs) m_cnt = 0;
        else if (dhs && m_cnt != RI) m_cnt++;
        if (shs) m_run = 1'b1;
        m_shs = shs;
        compare_all(tag);
    endtask

    task automatic rand_vec(output logic [NL*256-1:0] v);
        for (int i = 0; i < NL * 8; i++) v[i*32 +: 32] = $urandom;
    endtask

    // hold seed_valid until a seed handshake occurs (bounded)
    task automatic seed_until_taken(input string tag);
        logic done;
        done = 1'b0;
        seed_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick(tag);
            done = m_shs;
        end
        seed_valid = 1'b0;
        if (!done) check_val({tag, ".timeout"}, 512'd0, 512'd1);
    endtask

    initial begin
        logic done;
        rst_n = 1'b0; seed_valid = 1'b0; seed = '0; ent = '0; data_ready = 1'b0;
        model_reset();
        #12;
        check_val("rst.valid", 512'(data_valid), 512'd0);
        check_val("rst.rreq", 512'(reseed_req), 512'd1);
        check_val("rst.sready", 512'(seed_ready), 512'd1);
        check_val("rst.zero", 512'(all_zero), 512'd0);
        check_val("rst.data", 512'(data), 512'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // known seed on lane 0: a=1, b=c=d=0
        rand_vec(seed);
        seed[255:0] = {64'd1, 192'd0};
        data_ready = 1'b1;
        seed_valid = 1'b1;
        tick("seed");
        seed_valid = 1'b0;
        check_val("lat.t0", 512'(data_valid), 512'd0);
        tick("first");
        check_val("lat.t1", 512'(data_valid), 512'd1);
        check_val("kat.c0", 512'(data[63:0]), 512'h800001);
        check_val("kat.c1", 512'(data[127:64]), 512'h800001);
        tick("second");

        // randomized flow control, entropy and reseeds
        for (int i = 0; i < 200; i++) begin
            data_ready = ($urandom_range(0, 3) != 0);
            seed_valid = ($urandom_range(0, 15) == 0);
            rand_vec(seed);
            rand_vec(ent);
            tick("rand");
        end
        seed_valid = 1'b0;

        // reseed request after RI handshakes; generation keeps going
        data_ready = 1'b1;
        rand_vec(seed);
        seed_until_taken("rs.seed");
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick("rs.run");
            done = (m_cnt == RI);
        end
        if (!done) check_val("rs.timeout", 512'd0, 512'd1);
        check_val("rs.high", 512'(reseed_req), 512'd1);
        check_val("rs.valid", 512'(data_valid), 512'd1);
        tick("rs.hold");
        check_val("rs.still", 512'(reseed_req), 512'd1);
        seed_valid = 1'b1;
        tick("rs.take");
        seed_valid = 1'b0;
        check_val("rs.clear", 512'(reseed_req), 512'd0);

        // stall with valid high: word stable, states and counter frozen
        data_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick("stall");
        data_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick("resume");

        // all-zero seed on lane 0: lock-up recovery
        rand_vec(seed);
        seed[255:0] = 256'd0;
        seed_until_taken("lk.seed");
        check_val("lk.flag", 512'(all_zero[0]), 512'd1);
        tick("lk.word");
        check_val("lk.slice", 512'(data[LDW-1:0]), 512'd0);
        check_val("lk.clr", 512'(all_zero[0]), 512'd0);
        tick("lk.next");
        check_val("lk.dflt", 512'(data[63:0]), 512'(m_out(DSEED)));

        // all-ones entropy
        ent = '1;
        for (int i = 0; i < 6; i++) tick("ent1");

        // async reset mid-run with a pending word
        data_ready = 1'b0;
        tick("pre_rst");
        check_val("pre_rst.valid", 512'(data_valid), 512'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst.valid", 512'(data_valid), 512'd0);
        check_val("arst.rreq", 512'(reseed_req), 512'd1);
        check_val("arst.sready", 512'(seed_ready), 512'd1);
        model_reset();
        @(posedge clk); #1;
        compare_all("in_rst");
        rst_n = 1'b1;
        data_ready = 1'b1;
        rand_vec(seed);
        seed_until_taken("post.seed");
        for (int i = 0; i < 8; i++) tick("post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
